output_display_unit: RTL and testbench

//  Downstream consumer of the processor's output port (OUT bus + flagOUT strobe).
//  - Captures each written word and converts it to decimal with a sequential double-dabble FSM.
//  - Drives DIGITS static 7-segment displays (active-low), with leading-zero blanking.
//  - Sits between Processor and the board HEX pins; the processor never stalls on it.

---
 rtl/output_display_unit.sv | 164 ++++++++++++++++
 tb/tb_output_display_unit.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/output_display_unit.sv
// rtl/output_display_unit.sv - OUT-port word to DIGITS-wide 7-segment decimal display (double-dabble).
// Optional feature: define SIGNED_DISPLAY_EN to show OUT_Data as two's complement with a leading minus.
module output_display_unit #(
   parameter int DIGITS = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [31:0]           OUT_Data,
   input  logic                  flagOUT,
   output logic [7*DIGITS-1:0]   HEX,
   output logic                  busy,
   output logic                  overflow
);

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_MINUS = 7'h3F;
   // All digits blank except digit0 showing "0" (7F ^ 3F = 40).
   localparam logic [7*DIGITS-1:0] HEX_RST = {7*DIGITS{1'b1}} ^ (7*DIGITS)'(7'h3F);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'h40;
         4'd1:    seg7 = 7'h79;
         4'd2:    seg7 = 7'h24;
         4'd3:    seg7 = 7'h30;
         4'd4:    seg7 = 7'h19;
         4'd5:    seg7 = 7'h12;
         4'd6:    seg7 = 7'h02;
         4'd7:    seg7 = 7'h78;
         4'd8:    seg7 = 7'h00;
         4'd9:    seg7 = 7'h10;
         default: seg7 = SEG_BLANK;
      endcase
   endfunction

   state_t               state_q, state_d;
   logic [4:0]           cnt_q, cnt_d;
   logic [31:0]          bin_q, bin_d;
   logic [39:0]          bcd_q, bcd_d;
   logic                 neg_q, neg_d;
   logic                 pend_v_q, pend_v_d;
   logic [31:0]          pend_w_q, pend_w_d;
   logic [7*DIGITS-1:0]  hex_q, hex_d;
   logic                 ovf_q, ovf_d;
   logic                 busy_q, busy_d;

   logic [39:0]          bcd_adj;
   logic [31:0]          cap_word;
   int                   msd;
   logic                 hi_nz;
   logic                 ovf_f;
   logic [7*DIGITS-1:0]  hex_f;

   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < 10; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
   end

   // Formatting of the finished BCD value; only sampled into hex_q in DONE.
   always_comb begin
      msd   = 0;
      hi_nz = 1'b0;
      hex_f = '1;
      for (int i = 0; i < 10; i++) begin
         if (bcd_q[4*i +: 4] != 4'd0) begin
            if (i >= DIGITS) hi_nz = 1'b1;
            else             msd   = i;
         end
      end
      ovf_f = hi_nz || (neg_q && (msd + 1 >= DIGITS));
      for (int i = 0; i < DIGITS; i++) begin
         if (ovf_f)                       hex_f[7*i +: 7] = SEG_MINUS;
         else if (i <= msd)               hex_f[7*i +: 7] = seg7(bcd_q[4*i +: 4]);
         else if (neg_q && i == msd + 1)  hex_f[7*i +: 7] = SEG_MINUS;
         else                             hex_f[7*i +: 7] = SEG_BLANK;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bin_d    = bin_q;
      bcd_d    = bcd_q;
      neg_d    = neg_q;
      pend_v_d = pend_v_q;
      pend_w_d = pend_w_q;
      hex_d    = hex_q;
      ovf_d    = ovf_q;
      busy_d   = busy_q;
      cap_word = flagOUT ? OUT_Data : pend_w_q;

      if (flagOUT && state_q != IDLE) begin
         pend_v_d = 1'b1;
         pend_w_d = OUT_Data;
      end

      case (state_q)
         IDLE: begin
            if (flagOUT || pend_v_q) begin
`ifdef SIGNED_DISPLAY_EN
               neg_d = cap_word[31];
               bin_d = cap_word[31] ? (32'd0 - cap_word) : cap_word;
`else
               neg_d = 1'b0;
               bin_d = cap_word;
`endif
               pend_v_d = 1'b0;
               bcd_d    = '0;
               cnt_d    = '0;
               busy_d   = 1'b1;
               state_d  = SHIFT;
            end
         end
         SHIFT: begin
            bcd_d = {bcd_adj[38:0], bin_q[31]};
            bin_d = {bin_q[30:0], 1'b0};
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) state_d = DONE;
         end
         DONE: begin
            hex_d   = hex_f;
            ovf_d   = ovf_f;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         bin_q    <= '0;
         bcd_q    <= '0;
         neg_q    <= 1'b0;
         pend_v_q <= 1'b0;
         pend_w_q <= '0;
         hex_q    <= HEX_RST;
         ovf_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bin_q    <= bin_d;
         bcd_q    <= bcd_d;
         neg_q    <= neg_d;
         pend_v_q <= pend_v_d;
         pend_w_q <= pend_w_d;
         hex_q    <= hex_d;
         ovf_q    <= ovf_d;
         busy_q   <= busy_d;
      end
   end

   assign HEX      = hex_q;
   assign busy     = busy_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_output_display_unit.sv
// tb/tb_output_display_unit.sv - scoreboard bench for output_display_unit with a decimal reference model.
module tb_output_display_unit;

   localparam int D = 8;

   logic            clock = 1'b0;
   logic            reset;
   logic [31:0]     OUT_Data;
   logic            flagOUT;
   logic [7*D-1:0]  HEX;
   logic            busy;
   logic            overflow;

   output_display_unit #(.DIGITS(D)) dut (
      .clock    (clock),
      .reset    (reset),
      .OUT_Data (OUT_Data),
      .flagOUT  (flagOUT),
      .HEX      (HEX),
      .busy     (busy),
      .overflow (overflow)
   );

   always #5 clock = ~clock;

   typedef struct {
      int             start_e;
      int             end_e;
      logic [7*D-1:0] hex;
      logic           ovf;
   } exp_t;

   exp_t            q[$];
   int              checks = 0;
   int              errors = 0;
   int              edge_n = 0;
   bit              in_reset = 1'b1;
   int              conv_end = -100;
   bit              pend_v = 1'b0;
   logic [31:0]     pend_w = '0;
   logic [7*D-1:0]  cur_hex;
   logic            cur_ovf = 1'b0;

   always @(posedge clock) edge_n <= edge_n + 1;

   function automatic logic [6:0] seg_of(input int d);
      case (d)
         0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
         4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
         8: return 7'h00;  9: return 7'h10;
         default: return 7'h7F;
      endcase
   endfunction

   function automatic logic [7*D-1:0] rst_hex();
      logic [7*D-1:0] h;
      h = '1;
      h[6:0] = 7'h40;
      return h;
   endfunction

   // Reference: plain decimal arithmetic on the captured word.
   function automatic void exp_disp(input logic [31:0] w, output logic [7*D-1:0] hx, output logic ov);
      longint unsigned mag, t;
      bit neg;
      int nd;
      neg = 1'b0;
      mag = {32'd0, w};
`ifdef SIGNED_DISPLAY_EN
      if (w[31]) begin
         logic [31:0] nw;
         nw  = 32'd0 - w;
         neg = 1'b1;
         mag = {32'd0, nw};
      end
`endif
      nd = 1;
      t  = mag;
      while (t >= 10) begin
         t  = t / 10;
         nd++;
      end
      ov = (nd > D) || (neg && nd >= D);
      t  = mag;
      hx = '1;
      for (int i = 0; i < D; i++) begin
         if (ov)                   hx[7*i +: 7] = 7'h3F;
         else if (i < nd)          hx[7*i +: 7] = seg_of(int'(t % 10));
         else if (neg && i == nd)  hx[7*i +: 7] = 7'h3F;
         else                      hx[7*i +: 7] = 7'h7F;
         t = t / 10;
      end
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%h want=%h at edge %0d", name, got, want, edge_n);
      end
   endtask

   // Drive the inputs for the next edge and advance the transaction-level model.
   task automatic cycle(input logic f, input logic [31:0] d);
      int n;
      exp_t e;
      @(negedge clock);
      flagOUT  = f;
      OUT_Data = d;
      n = edge_n + 1;
      if (n > conv_end && (f || pend_v)) begin
         e.start_e = n;
         e.end_e   = n + 33;
         exp_disp(f ? d : pend_w, e.hex, e.ovf);
         q.push_back(e);
         conv_end = n + 33;
         pend_v   = 1'b0;
      end else if (f) begin
         pend_v = 1'b1;
         pend_w = d;
      end
   endtask

   task automatic drain();
      int g;
      g = 0;
      while ((q.size() != 0 || pend_v) && g < 300) begin
         cycle(1'b0, 32'd0);
         g++;
      end
      chk("drain_timeout", 64'(g < 300), 64'd1);
      repeat (2) cycle(1'b0, 32'd0);
   endtask

   function automatic logic [31:0] rand_word();
      case ($urandom_range(0, 4))
         0: return $urandom_range(0, 99);
         1: return $urandom_range(0, 99999999);
         2: return $urandom;
         3: return 32'd99999999 + $urandom_range(0, 2) - 32'd1;
         default: return ($urandom_range(0, 1) == 0) ? 32'h80000000 : 32'hFFFFFFFF;
      endcase
   endfunction

   // Monitor: final values at each scheduled DONE edge, no change in between, busy window.
   always @(negedge clock) begin
      if (!in_reset) begin
         if (q.size() > 0 && q[0].end_e == edge_n) begin
            chk("done_hex", 64'(HEX), 64'(q[0].hex));
            chk("done_ovf", 64'(overflow), 64'(q[0].ovf));
            cur_hex = q[0].hex;
            cur_ovf = q[0].ovf;
            void'(q.pop_front());
         end else begin
            chk("hold_hex", 64'(HEX), 64'(cur_hex));
            chk("hold_ovf", 64'(overflow), 64'(cur_ovf));
         end
         chk("busy", 64'(busy),
             64'(q.size() > 0 && q[0].start_e <= edge_n && edge_n < q[0].end_e));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at edge %0d", edge_n);
      $fatal(1, "watchdog");
   end

   initial begin
      cur_hex  = rst_hex();
      reset    = 1'b0;
      flagOUT  = 1'b0;
      OUT_Data = '0;
      #1 reset = 1'b1;
      repeat (2) @(negedge clock);
      chk("rst_hex", 64'(HEX), 64'({{6{7'h7F}}, 7'h7F, 7'h40}));
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_ovf", 64'(overflow), 64'd0);
      reset    = 1'b0;
      in_reset = 1'b0;
      repeat (3) cycle(1'b0, 32'd0);

      cycle(1'b1, 32'd1234);
      drain();
      chk("hex_1234", 64'(HEX), 64'({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30, 7'h19}));

      cycle(1'b1, 32'd99999999);
      drain();
      chk("hex_99999999", 64'(HEX), 64'({8{7'h10}}));
      chk("ovf_99999999", 64'(overflow), 64'd0);
      cycle(1'b1, 32'd100000000);
      drain();
      chk("hex_100000000", 64'(HEX), 64'({8{7'h3F}}));
      chk("ovf_100000000", 64'(overflow), 64'd1);
      cycle(1'b1, 32'd0);
      drain();
      chk("hex_zero", 64'(HEX), 64'({{7{7'h7F}}, 7'h40}));

      cycle(1'b1, 32'd5);
      repeat (9) cycle(1'b0, 32'd0);
      cycle(1'b1, 32'd7);
      repeat (9) cycle(1'b0, 32'd0);
      cycle(1'b1, 32'd9);
      drain();
      chk("hex_last_wins", 64'(HEX), 64'({{7{7'h7F}}, 7'h10}));

      cycle(1'b1, 32'd11);
      repeat (32) cycle(1'b0, 32'd0);
      cycle(1'b1, 32'd22);
      drain();
      chk("hex_strobe_at_done", 64'(HEX), 64'({{6{7'h7F}}, 7'h24, 7'h24}));

      cycle(1'b1, 32'hFFFFFFFB);
      drain();
`ifdef SIGNED_DISPLAY_EN
      chk("hex_minus5", 64'(HEX), 64'({{6{7'h7F}}, 7'h3F, 7'h12}));
      chk("ovf_minus5", 64'(overflow), 64'd0);
`else
      chk("hex_fffffffb", 64'(HEX), 64'({8{7'h3F}}));
      chk("ovf_fffffffb", 64'(overflow), 64'd1);
`endif

      cycle(1'b1, 32'd42);
      repeat (14) cycle(1'b0, 32'd0);
      @(negedge clock);
      flagOUT  = 1'b0;
      in_reset = 1'b1;
      reset    = 1'b1;
      #1;
      chk("midrst_hex", 64'(HEX), 64'(rst_hex()));
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_ovf", 64'(overflow), 64'd0);
      q.delete();
      pend_v   = 1'b0;
      conv_end = -100;
      cur_hex  = rst_hex();
      cur_ovf  = 1'b0;
      repeat (2) @(negedge clock);
      reset    = 1'b0;
      in_reset = 1'b0;
      repeat (40) cycle(1'b0, 32'd0);

      for (int k = 0; k < 600; k++) begin
         cycle($urandom_range(0, 15) == 0, rand_word());
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
